// File: rtl/serial_add_sequencer.sv
// Operand queue and load/start/done sequencer in front of the bit-serial adder.
// Supervises each add with a done-timeout and holds the result for downstream.
module serial_add_sequencer #(
   parameter int WIDTH   = 4,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             add_load,
   output logic             add_start,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH:0]   add_sum,
   input  logic             add_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             out_err,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + WIDTH) + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      WAIT_DONE,
      HOLD
   } state_t;

   state_t state, state_nx;

   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic               empty, full, push, pop;

   logic [CW-1:0] cnt;
   logic          cnt_clr;
   logic          cap, cap_err;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign pop      = (state == IDLE) && !empty;

   assign add_load  = (state == LOAD);
   assign add_start = (state == RUN);
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE) || !empty;

   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      cap      = 1'b0;
      cap_err  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) state_nx = LOAD;
         end
         LOAD: begin
            cnt_clr  = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            if (add_done) begin
               cap      = 1'b1;
               state_nx = HOLD;
            end else if (cnt == CW'(WIDTH - 1)) begin
               cnt_clr  = 1'b1;
               state_nx = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // A done arriving on the last allowed cycle still wins.
            if (add_done) begin
               cap      = 1'b1;
               state_nx = HOLD;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               cap      = 1'b1;
               cap_err  = 1'b1;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {in_a, in_b};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         add_a   <= '0;
         add_b   <= '0;
         out_sum <= '0;
         out_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_clr ? '0 : cnt + 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr         <= rd_ptr + 1'b1;
            {add_a, add_b} <= mem[rd_ptr[AW-1:0]];
         end
         if (cap) begin
            out_sum <= cap_err ? '0 : add_sum;
            out_err <= cap_err;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized bench for serial_add_sequencer with a behavioural adder and
// an in-order scoreboard of operand pairs and their expected results.
module tb_serial_add_sequencer;

   localparam int W = 4;
   localparam int D = 2;
   localparam int T = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         add_load, add_start;
   logic [W-1:0] add_a, add_b;
   logic [W:0]   add_sum = '0;
   logic         add_done = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W:0]   out_sum;
   logic         out_err;
   logic         busy;

   serial_add_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .add_load(add_load), .add_start(add_start),
      .add_a(add_a), .add_b(add_b),
      .add_sum(add_sum), .add_done(add_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_err(out_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // k: cycle after start falls on which the adder raises done (255 = never)
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           k;
   } op_t;

   typedef struct {
      logic [W:0] sum;
      logic       err;
   } res_t;

   op_t  pend_q[$];
   res_t res_q[$];
   op_t  cur;
   int   total = 0;
   int   bad = 0;
   int   run_len = 0;
   int   wcnt = 0;
   bit   in_wait = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Adder model and protocol/result monitor
   always @(negedge clk) begin
      add_done = 1'b0;
      if (rst) begin
         pend_q.delete();
         res_q.delete();
         in_wait = 0;
         run_len = 0;
      end else begin
         if (add_load) begin
            chk("load_pending", pend_q.size() != 0, 1);
            if (pend_q.size() != 0) begin
               res_t r;
               cur = pend_q.pop_front();
               chk("load_a", add_a, cur.a);
               chk("load_b", add_b, cur.b);
               add_sum = {1'b0, cur.a} + {1'b0, cur.b};
               r.err = (cur.k >= T);
               r.sum = r.err ? '0 : add_sum;
               res_q.push_back(r);
            end
         end
         if (add_start) begin
            run_len++;
         end else if (run_len != 0) begin
            chk("run_len", run_len, W);
            run_len = 0;
            in_wait = 1;
            wcnt = 0;
         end
         if (in_wait) begin
            if (out_valid) begin
               chk("latency", wcnt, (cur.k < T) ? cur.k + 1 : T);
               in_wait = 0;
            end else begin
               if (wcnt == cur.k) add_done = 1'b1;
               wcnt++;
            end
         end
         if (out_valid) chk("hold_noload", add_load, 0);
         if (out_valid && out_ready) begin
            chk("res_pending", res_q.size() != 0, 1);
            if (res_q.size() != 0) begin
               res_t e;
               e = res_q.pop_front();
               chk("out_sum", out_sum, e.sum);
               chk("out_err", out_err, e.err);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int k);
      int  n = 0;
      op_t op;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      while (!in_ready && n < 400) begin
         tick();
         n++;
      end
      chk("push_ready", in_ready, 1);
      if (in_ready) begin
         op.a = a;
         op.b = b;
         op.k = k;
         pend_q.push_back(op);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      chk(tag, out_valid, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || out_valid) && n < 3000) begin
         tick();
         n++;
      end
      chk("idle", busy, 0);
   endtask

   initial begin
      int n;
      int seen;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_add_start", add_start, 0);
      chk("rst_add_load", add_load, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_add_a", add_a, 0);

      // 13 + 11 with exact launch timing and a held result
      push(4'd13, 4'd11, 1);
      chk("t1_noload_c1", add_load, 0);
      tick();
      chk("t1_load_c2", add_load, 1);
      chk("t1_start_c2", add_start, 0);
      for (int i = 0; i < W; i++) begin
         tick();
         chk("t1_start_on", add_start, 1);
         chk("t1_load_off", add_load, 0);
      end
      tick();
      chk("t1_start_off", add_start, 0);
      wait_valid("t1_valid");
      for (int i = 0; i < 3; i++) begin
         chk("t1_hold_valid", out_valid, 1);
         chk("t1_hold_sum", out_sum, 24);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("t1_release", out_valid, 0);
      wait_idle();

      // back-to-back pairs, including carry-out
      push(4'd15, 4'd15, 1);
      push(4'd0, 4'd0, 2);
      wait_idle();

      // backpressure: queue fills while result is held
      out_ready = 1'b0;
      push(4'd1, 4'd2, 1);
      wait_valid("t3_valid");
      push(4'd3, 4'd4, 1);
      push(4'd5, 4'd6, 1);
      in_a = 4'd7;
      in_b = 4'd8;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_full", in_ready, 0);
         chk("t3_held", out_valid, 1);
      end
      out_ready = 1'b1;
      tick();
      chk("t3_still_full", in_ready, 0);
      tick();
      chk("t3_reopen", in_ready, 1);
      begin
         op_t op;
         op.a = 4'd7;
         op.b = 4'd8;
         op.k = 0;
         pend_q.push_back(op);
      end
      tick();
      in_valid = 1'b0;
      wait_idle();

      // timeout then a normal op
      push(4'd2, 4'd3, 255);
      push(4'd4, 4'd5, 1);
      wait_idle();

      // done coinciding with timeout, then one cycle too late
      push(4'd9, 4'd8, T - 1);
      push(4'd1, 4'd1, T);
      wait_idle();

      // reset in the second RUN cycle with one pair queued
      push(4'd6, 4'd7, 1);
      push(4'd8, 4'd9, 1);
      n = 0;
      while (!add_start && n < 50) begin
         tick();
         n++;
      end
      chk("t5_run", add_start, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_start", add_start, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_ready", in_ready, 1);
      chk("t5_sum", out_sum, 0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (add_load || out_valid) seen++;
      end
      chk("t5_silent", seen, 0);

      // randomized traffic with random done timing and backpressure
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               int k;
               k = ($urandom_range(0, 5) == 0) ? 255 :
                   int'($urandom_range(0, T + 1));
               push(W'($urandom), W'($urandom), k);
               if ($urandom_range(0, 3) == 0) repeat (3) tick();
            end
         end
         begin
            repeat (700) begin
               tick();
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_idle();
      chk("drained_res", res_q.size(), 0);
      chk("drained_pend", pend_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Control stage directly upstream of the 4-bit bit-serial adder.
- Accepts operand pairs over a valid/ready stream and buffers them in a small queue.
- Drives the adder's load/start protocol and waits for done, then presents the (WIDTH+1)-bit sum on a valid/ready output stream.
- Supervises the adder with a done-timeout and flags stalled operations.

Parameters:
- WIDTH, 4: operand width; also the number of add_start cycles per operation.
- DEPTH, 2: operand queue entries; must be a power of 2 and at least 2.
- TIMEOUT, 16: max cycles in WAIT_DONE before an operation is aborted.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  queue can accept; equals !full.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- add_load  out  1  one-cycle load pulse to the adder.
- add_start  out  1  start level to the adder, high for WIDTH cycles.
- add_a  out  WIDTH  registered operand A to the adder.
- add_b  out  WIDTH  registered operand B to the adder.
- add_sum  in  WIDTH+1  adder result, including carry-out in the MSB.
- add_done  in  1  adder completion flag.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH+1  captured sum.
- out_err  out  1  result aborted by timeout; qualified by out_valid.
- busy  out  1  high in any state other than IDLE, or when the queue is non-empty.

Behaviour:
- Reset: synchronous, active-high, with priority over all other events, including mid-operation.
  - FSM returns to IDLE and the queue is emptied.
  - Outputs cleared: add_load=0, add_start=0, add_a=0, add_b=0, out_valid=0, out_sum=0, out_err=0, busy=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - An in-flight operation is discarded with no result.
- Queue: DEPTH-entry FIFO with wrap-around pointers and an extra count bit.
  - Push occurs when in_valid && in_ready.
  - in_ready=0 when full, so a push into a full queue cannot occur.
  - Pop only on the IDLE->LOAD transition.
  - Push and pop in the same cycle are legal when the queue is non-full; count stays unchanged.
- FSM states: IDLE, LOAD, RUN, WAIT_DONE, HOLD.
  - IDLE: if the queue is non-empty, pop the head into add_a/add_b and go to LOAD.
  - LOAD, one cycle: add_load=1, add_start=0. Go to RUN next cycle.
  - RUN: add_start=1 for exactly WIDTH consecutive cycles, counted by a cycle counter. Then go to WAIT_DONE. add_done sampled high in RUN goes directly to capture.
  - WAIT_DONE: add_start=0. A timeout counter starts at 0 on entry.
    - add_done=1: capture out_sum=add_sum, out_err=0, go to HOLD.
    - Counter reaches TIMEOUT-1 without done: capture out_sum=0, out_err=1, go to HOLD.
    - If done and timeout coincide, done wins.
  - HOLD: out_valid=1, with out_sum/out_err stable. When out_ready=1, clear out_valid and go to IDLE.
- Sampling: add_done is sampled only in RUN and WAIT_DONE; it is ignored in IDLE, LOAD and HOLD.
- Output stability: add_a/add_b hold their value from LOAD until the next pop.
- Latency with an empty queue and out_ready=1 (push at cycle 0):
  - add_load high at cycle 2.
  - add_start high for cycles 3..3+WIDTH-1.
  - out_valid high the cycle after add_done is sampled.
- Backpressure: while in HOLD, no new operation is launched. The queue keeps accepting until full.
- Arithmetic: no truncation; the carry-out is preserved in out_sum[WIDTH].

Test Plan:
- Push A=13, B=11; adder model asserts done 1 cycle after start falls with add_sum=24 -> add_load one cycle, add_start exactly 4 cycles, out_sum=5'b11000, out_err=0, out_valid until out_ready.
- Push A=15, B=15 then A=0, B=0 back-to-back with out_ready=1 -> two results in order: 30 (5'b11110), then 0; add_a/add_b equal 15/15, then 0/0 at each add_load.
- Hold out_ready=0 after the first result; push 3 more pairs -> in_ready drops after 2 queued (DEPTH=2), no add_load while in HOLD, in_ready re-asserts one cycle after out_ready frees the FSM and a pop occurs.
- Adder model never asserts done -> exactly TIMEOUT cycles after entering WAIT_DONE: out_valid=1, out_err=1, out_sum=0; next queued pair proceeds normally.
- Assert rst in the 2nd RUN cycle with 1 pair queued -> next cycle add_start=0, out_valid=0, busy=0, in_ready=1; queued pair discarded, no result emitted.
- Assert add_done on the same cycle the timeout expires -> out_err=0, out_sum=add_sum.
